// File: rtl/board_pkg.sv
// Shared sizes, FSM encoding and cell addressing for the 32x16 board bitmap.
package board_pkg;
  localparam int unsigned ROWS   = 32;
  localparam int unsigned COLS   = 16;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CELLS  = ROWS * COLS;
  localparam logic        CLEAR_VAL = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW_WR = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/board_bitmem.sv
// 512x1 bit storage: one synchronous write port, one asynchronous read port, no reset.
module board_bitmem
  import board_pkg::*;
(
  input  logic              clk_25mhz,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_rdata_c
);
  logic r_mem [CELLS];

  always_ff @(posedge clk_25mhz) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];
endmodule

// File: rtl/board_bitmap_writer.sv
// Serialises row writes and full-board clears into one bit-write per cycle;
// the VGA side reads the same storage combinationally.
module board_bitmap_writer
  import board_pkg::*;
(
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COLS-1:0]   wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] Bit_addr,
  output logic              bitin
);
  state_t             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COLS-1:0]    r_data;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_cnt;
  logic               r_busy;
  logic               r_done;

  logic               w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic               w_wdata;

  // Write port follows the registered state, so reset stops writes at once.
  assign w_we    = (r_state != IDLE);
  assign w_waddr = (r_state == ROW_WR) ? cell_addr(r_row, r_col) : r_cnt;
  assign w_wdata = (r_state == ROW_WR) ? r_data[r_col] : CLEAR_VAL;

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_data  <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Clear takes priority; a coincident row write is dropped.
          if (clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (wr_req) begin
            r_state <= ROW_WR;
            r_row   <= wr_row;
            r_data  <= wr_data;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ROW_WR: begin
          r_col <= r_col + COL_W'(1);
          if (r_col == COL_W'(COLS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(CELLS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  board_bitmem u_mem (
    .clk_25mhz (clk_25mhz),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr   (Bit_addr),
    .o_rdata_c (bitin)
  );
endmodule

// File: tb/tb_board_bitmap_writer.sv
// Bench for board_bitmap_writer: directed scenarios plus randomized writes/clears against a flat bit-image model.
module tb_board_bitmap_writer;
  logic        clk_25mhz = 1'b0;
  logic        reset     = 1'b0;
  logic        wr_req    = 1'b0;
  logic [4:0]  wr_row    = '0;
  logic [15:0] wr_data   = '0;
  logic        clr_req   = 1'b0;
  logic [8:0]  Bit_addr  = '0;
  logic        busy, done, bitin;

  int n_vec = 0;
  int n_err = 0;
  logic [511:0] model;

  always #5 clk_25mhz = ~clk_25mhz;

  board_bitmap_writer dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .done      (done),
    .Bit_addr  (Bit_addr),
    .bitin     (bitin)
  );

  task automatic model_row(input logic [4:0] row, input logic [15:0] data, input int ncols);
    for (int c = 0; c < ncols; c++) model[int'(row) * 16 + c] = data[c];
  endtask

  task automatic read_board(output logic [511:0] img);
    for (int a = 0; a < 512; a++) begin
      Bit_addr = 9'(a);
      #1;
      img[a] = bitin;
    end
  endtask

  // Called on the falling edge just after acceptance; counts busy cycles.
  task automatic run_until_idle(input int budget, output int cycles,
                                output logic done_end, output logic done_after);
    cycles = 0;
    while (busy === 1'b1 && cycles < budget) begin
      cycles++;
      @(negedge clk_25mhz);
    end
    done_end = done;
    @(negedge clk_25mhz);
    done_after = done;
  endtask

  task automatic test_reset();
    wr_req = 1'b1; clr_req = 1'b1; wr_row = 5'd1; wr_data = 16'hFFFF;
    repeat (3) @(negedge clk_25mhz);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs busy=%b done=%b required 0 0", busy, done);
    end
    wr_req = 1'b0; clr_req = 1'b0;
    reset = 1'b1;
    @(negedge clk_25mhz);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release_busy busy=%b required 0", busy);
    end
  endtask

  task automatic test_clear();
    int cyc; logic d0, d1; logic [511:0] img;
    clr_req = 1'b1;
    @(negedge clk_25mhz);
    clr_req = 1'b0;
    run_until_idle(600, cyc, d0, d1);
    n_vec++;
    if (cyc != 512 || d0 !== 1'b1 || d1 !== 1'b0) begin
      n_err++; $display("FAIL clear_timing busy_cycles=%0d done=%b,%b required 512 1,0", cyc, d0, d1);
    end
    model = '0;
    read_board(img);
    n_vec++;
    if (img !== model) begin
      n_err++; $display("FAIL clear_image got %h required %h", img, model);
    end
  endtask

  task automatic test_row_write_ignored();
    int cyc; int dones; logic [511:0] img;
    wr_req = 1'b1; wr_row = 5'd3; wr_data = 16'hA5F0;
    @(negedge clk_25mhz);
    wr_req = 1'b0;
    cyc = 0; dones = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done === 1'b1) dones++;
      if (cyc == 5) begin wr_req = 1'b1; wr_row = 5'd5; wr_data = 16'hFFFF; end
      if (cyc == 6) wr_req = 1'b0;
      @(negedge clk_25mhz);
    end
    repeat (4) begin
      if (done === 1'b1) dones++;
      @(negedge clk_25mhz);
    end
    n_vec++;
    if (cyc != 16 || dones != 1) begin
      n_err++; $display("FAIL row_write_timing busy_cycles=%0d done_pulses=%0d required 16 1", cyc, dones);
    end
    model_row(5'd3, 16'hA5F0, 16);
    read_board(img);
    n_vec++;
    if (img !== model) begin
      n_err++; $display("FAIL row3_image got %h required %h", img, model);
    end
    n_vec++;
    if (img[9'h030] !== 1'b0 || img[9'h035] !== 1'b1 || img[9'h03F] !== 1'b1) begin
      n_err++; $display("FAIL row3_cells 030=%b 035=%b 03F=%b required 0 1 1",
                        img[9'h030], img[9'h035], img[9'h03F]);
    end
  endtask

  task automatic test_clear_beats_write();
    int cyc; logic d0, d1; logic [511:0] img;
    clr_req = 1'b1; wr_req = 1'b1; wr_row = 5'd0; wr_data = 16'hFFFF;
    @(negedge clk_25mhz);
    clr_req = 1'b0; wr_req = 1'b0;
    run_until_idle(600, cyc, d0, d1);
    n_vec++;
    if (cyc != 512 || d0 !== 1'b1) begin
      n_err++; $display("FAIL clr_priority_timing busy_cycles=%0d done=%b required 512 1", cyc, d0);
    end
    model = '0;
    read_board(img);
    n_vec++;
    if (img !== model) begin
      n_err++; $display("FAIL clr_priority_image got %h required %h", img, model);
    end
  endtask

  task automatic test_reset_midop();
    logic [511:0] img;
    wr_req = 1'b1; wr_row = 5'd7; wr_data = 16'hFFFF;
    @(negedge clk_25mhz);
    wr_req = 1'b0;
    repeat (8) @(negedge clk_25mhz);
    reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midop_reset busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk_25mhz);
    reset = 1'b1;
    @(negedge clk_25mhz);
    model_row(5'd7, 16'hFFFF, 8);
    read_board(img);
    n_vec++;
    if (img !== model) begin
      n_err++; $display("FAIL midop_image got %h required %h", img, model);
    end
  endtask

  task automatic test_top_row();
    int cyc; logic d0, d1; logic [511:0] img;
    wr_req = 1'b1; wr_row = 5'd31; wr_data = 16'h8001;
    @(negedge clk_25mhz);
    wr_req = 1'b0;
    run_until_idle(100, cyc, d0, d1);
    n_vec++;
    if (cyc != 16 || d0 !== 1'b1 || d1 !== 1'b0) begin
      n_err++; $display("FAIL row31_timing busy_cycles=%0d done=%b,%b required 16 1,0", cyc, d0, d1);
    end
    model_row(5'd31, 16'h8001, 16);
    read_board(img);
    n_vec++;
    if (img !== model || img[496] !== 1'b1 || img[511] !== 1'b1) begin
      n_err++; $display("FAIL row31_image got %h required %h", img, model);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic d0, d1; logic [511:0] img; logic [15:0] data;
    data = 16'($urandom);
    wr_req = 1'b1; wr_row = 5'd10; wr_data = data;
    @(negedge clk_25mhz);
    run_until_idle(100, cyc, d0, d1);
    n_vec++;
    if (cyc != 16 || d0 !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL held_req_retrigger busy_cycles=%0d done=%b busy_after=%b required 16 1 1",
                        cyc, d0, busy);
    end
    wr_req = 1'b0;
    run_until_idle(100, cyc, d0, d1);
    n_vec++;
    if (cyc != 16 || d0 !== 1'b1 || d1 !== 1'b0) begin
      n_err++; $display("FAIL second_write_timing busy_cycles=%0d done=%b,%b required 16 1,0", cyc, d0, d1);
    end
    model_row(5'd10, data, 16);
    read_board(img);
    n_vec++;
    if (img !== model) begin
      n_err++; $display("FAIL back_to_back_image got %h required %h", img, model);
    end
  endtask

  task automatic test_random();
    int cyc; int k; int exp_cyc; logic is_clr; logic [4:0] row; logic [15:0] data;
    logic [511:0] img;
    for (int it = 0; it < 24; it++) begin
      is_clr = ($urandom_range(0, 7) == 0);
      row = 5'($urandom); data = 16'($urandom);
      k = $urandom_range(1, 8);
      clr_req = is_clr; wr_req = 1'b1; wr_row = row; wr_data = data;
      @(negedge clk_25mhz);
      clr_req = 1'b0; wr_req = 1'b0;
      exp_cyc = is_clr ? 512 : 16;
      cyc = 0;
      while (busy === 1'b1 && cyc < 600) begin
        cyc++;
        if (cyc == k) begin
          wr_req = 1'($urandom); clr_req = 1'($urandom);
          wr_row = 5'($urandom); wr_data = 16'($urandom);
        end
        if (cyc == k + 1) begin wr_req = 1'b0; clr_req = 1'b0; end
        @(negedge clk_25mhz);
      end
      n_vec++;
      if (cyc != exp_cyc || done !== 1'b1) begin
        n_err++; $display("FAIL rand_timing it=%0d busy_cycles=%0d done=%b required %0d 1",
                          it, cyc, done, exp_cyc);
      end
      @(negedge clk_25mhz);
      if (is_clr) model = '0;
      else model_row(row, data, 16);
      read_board(img);
      n_vec++;
      if (img !== model) begin
        n_err++; $display("FAIL rand_image it=%0d got %h required %h", it, img, model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_row_write_ignored();
    test_clear_beats_write();
    test_reset_midop();
    test_top_row();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
